// File: rtl/counter_bcd_updown.sv
// Up/down tick counter with a lockstep BCD digit vector for the FND path.
// Parallel load converts the binary value to BCD with a sequential double-dabble.
module counter_bcd_updown #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned MAX_VAL = 9999,
  parameter int unsigned WIDTH   = $clog2(MAX_VAL + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_tick,
  input  logic                  mode,
  input  logic                  sat_en,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  output logic [WIDTH-1:0]      count,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  o_busy,
  output logic                  o_wrap,
  output logic                  o_at_limit
);

  localparam int unsigned BW  = 4 * DIGITS;
  localparam int unsigned ITW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  function automatic logic [BW-1:0] to_bcd(input int unsigned v);
    logic [BW-1:0] r;
    int unsigned   x;
    r = '0;
    x = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Ripple +1 across digits; 9 rolls to 0 and carries on.
  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Ripple -1 across digits; 0 rolls to 9 and borrows on.
  function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // One double-dabble iteration: add 3 to digits >= 5, then shift in the next bit.
  function automatic logic [BW-1:0] dd_step(input logic [BW-1:0] acc, input logic bit_in);
    logic [BW-1:0] a;
    a = acc;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return {a[BW-2:0], bit_in};
  endfunction

  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [BW-1:0]    MAX_BCD = to_bcd(MAX_VAL);

  if ((MAX_VAL < 1) || (64'(MAX_VAL) > (pow10(DIGITS) - 64'd1))) begin : g_param_check
    $error("counter_bcd_updown: MAX_VAL must be in 1 .. 10**DIGITS-1");
  end

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic [BW-1:0]    r_bcd,   w_bcd_nxt;
  logic             r_wrap,  w_wrap_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [BW-1:0]    r_acc,   w_acc_nxt;
  logic [ITW-1:0]   r_iter,  w_iter_nxt;
  logic [WIDTH-1:0] w_load_clamp;
  logic [BW-1:0]    w_dd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_bcd   <= '0;
      r_wrap  <= 1'b0;
      r_shift <= '0;
      r_acc   <= '0;
      r_iter  <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_bcd   <= w_bcd_nxt;
      r_wrap  <= w_wrap_nxt;
      r_shift <= w_shift_nxt;
      r_acc   <= w_acc_nxt;
      r_iter  <= w_iter_nxt;
    end
  end

  // Next-state and datapath; priority clear > load > tick.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_bcd_nxt    = r_bcd;
    w_wrap_nxt   = 1'b0;
    w_shift_nxt  = r_shift;
    w_acc_nxt    = r_acc;
    w_iter_nxt   = r_iter;
    w_load_clamp = (load_val > MAX_W) ? MAX_W : load_val;
    w_dd         = dd_step(r_acc, r_shift[WIDTH-1]);

    case (r_state)
      S_IDLE: begin
        if (clear) begin
          w_count_nxt = '0;
          w_bcd_nxt   = '0;
        end else if (load) begin
          w_count_nxt = w_load_clamp;
          w_shift_nxt = w_load_clamp;
          w_acc_nxt   = '0;
          w_iter_nxt  = '0;
          w_state_nxt = S_CONV;
        end else if (i_tick) begin
          if (!mode) begin
            if (r_count < MAX_W) begin
              w_count_nxt = r_count + WIDTH'(1);
              w_bcd_nxt   = bcd_inc(r_bcd);
            end else if (!sat_en) begin
              w_count_nxt = '0;
              w_bcd_nxt   = '0;
              w_wrap_nxt  = 1'b1;
            end
          end else begin
            if (r_count != '0) begin
              w_count_nxt = r_count - WIDTH'(1);
              w_bcd_nxt   = bcd_dec(r_bcd);
            end else if (!sat_en) begin
              w_count_nxt = MAX_W;
              w_bcd_nxt   = MAX_BCD;
              w_wrap_nxt  = 1'b1;
            end
          end
        end
      end
      S_CONV: begin
        if (clear) begin
          w_count_nxt = '0;
          w_bcd_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_acc_nxt   = w_dd;
          w_shift_nxt = r_shift << 1;
          w_iter_nxt  = r_iter + ITW'(1);
          if (r_iter == ITW'(WIDTH - 1)) begin
            w_bcd_nxt   = w_dd;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign count      = r_count;
  assign bcd        = r_bcd;
  assign o_wrap     = r_wrap;
  assign o_busy     = (r_state == S_CONV);
  assign o_at_limit = mode ? (r_count == '0) : (r_count == MAX_W);

endmodule

// File: tb/tb_counter_bcd_updown.sv
// Directed bench for counter_bcd_updown: default 4-digit instance plus a 2-digit/59 variant.
module tb_counter_bcd_updown;

  localparam int unsigned W  = 14;
  localparam int unsigned W2 = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_tick, mode, sat_en, clear, load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  count;
  logic [15:0]   bcd;
  logic          o_busy, o_wrap, o_at_limit;

  logic          v_tick;
  logic [W2-1:0] v_count;
  logic [7:0]    v_bcd;
  logic          v_busy, v_wrap, v_at_limit;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  counter_bcd_updown #(.DIGITS(4), .MAX_VAL(9999)) dut (
    .clk(clk), .rst_n(rst_n), .i_tick(i_tick), .mode(mode), .sat_en(sat_en),
    .clear(clear), .load(load), .load_val(load_val), .count(count), .bcd(bcd),
    .o_busy(o_busy), .o_wrap(o_wrap), .o_at_limit(o_at_limit)
  );

  counter_bcd_updown #(.DIGITS(2), .MAX_VAL(59)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_tick(v_tick), .mode(1'b0), .sat_en(1'b0),
    .clear(1'b0), .load(1'b0), .load_val(6'd0), .count(v_count), .bcd(v_bcd),
    .o_busy(v_busy), .o_wrap(v_wrap), .o_at_limit(v_at_limit)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input logic m, input logic s);
    mode   = m;
    sat_en = s;
    i_tick = 1'b1;
    step();
    i_tick = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load_val = v;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  // Counts cycles until o_busy drops, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (o_busy && n < 100) begin
      step();
      n++;
    end
  endtask

  int  n;
  logic wrap_seen;

  initial begin
    rst_n = 1'b0; i_tick = 1'b0; mode = 1'b0; sat_en = 1'b0;
    clear = 1'b0; load = 1'b0; load_val = '0; v_tick = 1'b0;
    step();
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_bcd",   64'(bcd),   64'h0);
    check_eq("rst_busy",  64'(o_busy), 64'd0);
    check_eq("rst_wrap",  64'(o_wrap), 64'd0);
    rst_n = 1'b1;
    step();

    // 10 up-ticks from zero
    wrap_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      do_tick(1'b0, 1'b0);
      wrap_seen |= o_wrap;
    end
    check_eq("up10_count", 64'(count), 64'd10);
    check_eq("up10_bcd",   64'(bcd),   64'h0010);
    check_eq("up10_wrap",  64'(wrap_seen), 64'd0);

    // load 9998, conversion latency, then wrap upward
    do_load(14'd9998);
    check_eq("ld9998_busy",  64'(o_busy), 64'd1);
    check_eq("ld9998_count", 64'(count),  64'd9998);
    wait_idle(n);
    check_eq("ld9998_lat",   64'(n),      64'd14);
    check_eq("ld9998_bcd",   64'(bcd),    64'h9998);
    do_tick(1'b0, 1'b0);
    check_eq("to9999_count", 64'(count),  64'd9999);
    check_eq("to9999_bcd",   64'(bcd),    64'h9999);
    check_eq("to9999_lim",   64'(o_at_limit), 64'd1);
    check_eq("to9999_wrap",  64'(o_wrap), 64'd0);
    do_tick(1'b0, 1'b0);
    check_eq("wrapup_count", 64'(count),  64'd0);
    check_eq("wrapup_bcd",   64'(bcd),    64'h0000);
    check_eq("wrapup_pulse", 64'(o_wrap), 64'd1);
    step();
    check_eq("wrapup_end",   64'(o_wrap), 64'd0);

    // down-wrap from zero, then saturate at zero
    do_tick(1'b1, 1'b0);
    check_eq("wrapdn_count", 64'(count),  64'd9999);
    check_eq("wrapdn_bcd",   64'(bcd),    64'h9999);
    check_eq("wrapdn_pulse", 64'(o_wrap), 64'd1);
    step();
    check_eq("wrapdn_end",   64'(o_wrap), 64'd0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_eq("clr_count",    64'(count),  64'd0);
    do_tick(1'b1, 1'b1);
    check_eq("satdn_count",  64'(count),  64'd0);
    check_eq("satdn_wrap",   64'(o_wrap), 64'd0);
    check_eq("satdn_lim",    64'(o_at_limit), 64'd1);

    // clamp on load; ticks during conversion are dropped
    do_load(14'd12000);
    check_eq("clamp_count",  64'(count),  64'd9999);
    mode = 1'b0; sat_en = 1'b0; i_tick = 1'b1;
    wrap_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      wrap_seen |= o_wrap;
    end
    i_tick = 1'b0;
    check_eq("conv_tick_count", 64'(count), 64'd9999);
    check_eq("conv_tick_wrap",  64'(wrap_seen), 64'd0);
    wait_idle(n);
    check_eq("clamp_idle",   64'(n < 100), 64'd1);
    check_eq("clamp_bcd",    64'(bcd),    64'h9999);

    // borrow cascade across three digits
    do_load(14'd1000);
    wait_idle(n);
    check_eq("ld1000_bcd",   64'(bcd),    64'h1000);
    do_tick(1'b1, 1'b0);
    check_eq("borrow_count", 64'(count),  64'd999);
    check_eq("borrow_bcd",   64'(bcd),    64'h0999);

    // clear on the fifth conversion cycle aborts it
    do_load(14'd4321);
    repeat (4) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_eq("abort_count",  64'(count),  64'd0);
    check_eq("abort_bcd",    64'(bcd),    64'h0);
    check_eq("abort_busy",   64'(o_busy), 64'd0);
    do_load(14'd55);
    wait_idle(n);
    check_eq("ld55_count",   64'(count),  64'd55);
    check_eq("ld55_bcd",     64'(bcd),    64'h0055);

    // clear wins over load and tick on the same edge
    clear = 1'b1; load = 1'b1; load_val = 14'd100; i_tick = 1'b1; mode = 1'b0;
    step();
    clear = 1'b0; load = 1'b0; i_tick = 1'b0;
    check_eq("prio_count",   64'(count),  64'd0);
    check_eq("prio_bcd",     64'(bcd),    64'h0);
    check_eq("prio_busy",    64'(o_busy), 64'd0);

    // asynchronous reset between edges, while counting and mid-conversion
    repeat (3) do_tick(1'b0, 1'b0);
    check_eq("pre_rst_count", 64'(count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_count",   64'(count),  64'd0);
    check_eq("arst_bcd",     64'(bcd),    64'h0);
    rst_n = 1'b1;
    step();
    do_load(14'd77);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_conv_busy",  64'(o_busy), 64'd0);
    check_eq("arst_conv_count", 64'(count),  64'd0);
    rst_n = 1'b1;
    step();

    // 2-digit variant: 59 then wrap
    v_tick = 1'b1;
    repeat (59) step();
    check_eq("v59_count",    64'(v_count), 64'd59);
    check_eq("v59_bcd",      64'(v_bcd),   64'h59);
    step();
    v_tick = 1'b0;
    check_eq("v60_count",    64'(v_count), 64'd0);
    check_eq("v60_bcd",      64'(v_bcd),   64'h00);
    check_eq("v60_wrap",     64'(v_wrap),  64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_bcd_updown.md
Name: counter_bcd_updown

Overview:
- Parametrised successor to the fixed 0..9999 up/down tick counter feeding the FND display path.
- Keeps a binary count and a lockstep BCD digit vector, so the FND driver needs no divider.
- Adds wrap/saturate mode, parallel load with sequential binary-to-BCD conversion, a wrap pulse and a limit flag.
- Sits between the tick generator / UART-FIFO command decoder and the FND controller.

Parameters:
- DIGITS, 4: number of BCD digits presented.
- MAX_VAL, 9999: terminal count. Must be ≥1 and ≤10^DIGITS−1; an elaboration-time check fails otherwise.
- WIDTH, $clog2(MAX_VAL+1): binary count width, derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_tick  in  1  one-cycle count-enable strobe.
- mode  in  1  0 = count up, 1 = count down.
- sat_en  in  1  0 = wrap at limits, 1 = saturate at limits.
- clear  in  1  synchronous clear.
- load  in  1  one-cycle parallel-load strobe.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  binary count.
- bcd  out  4*DIGITS  BCD digits; digit 0 in bits [3:0].
- o_busy  out  1  BCD conversion in progress.
- o_wrap  out  1  one-cycle pulse on wrap-around.
- o_at_limit  out  1  count sits at the limit for the current direction.

Behaviour:
- Reset (rst_n=0, asynchronous): count=0, bcd=0, o_busy=0, o_wrap=0, FSM=IDLE.
- Priority each edge: clear > load > i_tick.
- FSM has two states, IDLE and CONV.
- IDLE + clear: count=0, bcd=0 at the next edge.
- IDLE + load: count=min(load_val, MAX_VAL) at the same edge. Go to CONV, o_busy=1. Shift register holds the clamped value; BCD accumulator is cleared; iteration counter=0.
- CONV: one double-dabble iteration per clock (add 3 to every digit ≥5, then shift left one bit). After WIDTH iterations, i.e. WIDTH cycles after the load edge, bcd takes the result, o_busy=0 and the FSM returns to IDLE on that same edge. For MAX_VAL=9999 this is 14 cycles.
- CONV + clear: abort conversion, count=0, bcd=0, o_busy=0, go to IDLE.
- CONV + load: ignored.
- CONV + i_tick: dropped, not queued. count and bcd hold.
- IDLE + i_tick, mode=0:
  - count<MAX_VAL: count+1, and bcd increments with a digit-cascade carry (digit 9→0 carries into the next digit).
  - count==MAX_VAL, sat_en=0: count=0, bcd=0, o_wrap=1 for the next cycle.
  - count==MAX_VAL, sat_en=1: hold, no pulse.
- IDLE + i_tick, mode=1:
  - count>0: count−1, and bcd decrements with a digit-cascade borrow (0→9 borrows).
  - count==0, sat_en=0: count=MAX_VAL, bcd=BCD(MAX_VAL) (a constant), o_wrap=1.
  - count==0, sat_en=1: hold, no pulse.
- o_wrap is registered. It is high exactly the one cycle after the wrapping edge and otherwise 0, including after clear and load.
- o_at_limit is combinational: (mode=0 and count==MAX_VAL) or (mode=1 and count==0). It ignores o_busy.
- mode and sat_en are sampled only on tick edges; a change between ticks has no other effect.
- Invariant: whenever o_busy=0, bcd equals the decimal digits of count.
- Reset asserted mid-CONV returns everything to reset values immediately.

Test Plan:
- Reset, then 10 ticks with mode=0 → count=10, bcd=0x0010, o_wrap never asserted.
- load 9998, wait until o_busy=0; check o_busy high exactly 14 cycles and bcd=0x9998. Then 2 ticks with mode=0, sat_en=0 → 9999 then 0, o_wrap pulses once, bcd=0x0000.
- Count=0, mode=1, sat_en=0, tick → count=9999, bcd=0x9999, o_wrap=1 for one cycle. Repeat with sat_en=1 → count stays 0, o_at_limit=1, no pulse.
- load 12000 → count clamps to 9999, bcd=0x9999 after conversion. Ticks issued during CONV leave count at 9999.
- load 4321, then clear on cycle 5 of CONV → count=0, bcd=0, o_busy=0 next cycle. A following load 0055 gives bcd=0x0055.
- Same edge carries clear+load+tick → clear wins. Separately, rst_n pulsed low mid-count (async, between edges) → all outputs 0 immediately.
- Parameter variant DIGITS=2, MAX_VAL=59: 60 up-ticks from 0 → wraps to 0, bcd=0x00. Check bcd=0x59 one tick earlier.
